// File: rtl/led_control_multi.sv
// led_control_multi: front-panel LED driver with event flash stretchers, bouncing cylon scan,
// host pattern, PWM dimming and an error blink that overrides every mode.
module led_control_multi #(
  parameter int N_LEDS         = 16,
  parameter int N_EVENTS       = 8,
  parameter int FLASH_CYCLES   = 2000000,
  parameter int BLINK_DIV_BITS = 21,
  parameter int CYLON_DIV_BITS = 20,
  parameter int PWM_BITS       = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [1:0]          mode_i,
  input  logic                err_i,
  input  logic                clear_i,
  input  logic [N_EVENTS-1:0] event_i,
  input  logic [N_LEDS-1:0]   status_i,
  input  logic [N_LEDS-1:0]   host_data_i,
  input  logic [PWM_BITS-1:0] brightness_i,
  output logic [N_LEDS-1:0]   led_o,
  output logic                activity_seen_o
);
  localparam int FW = $clog2(FLASH_CYCLES + 1);
  localparam int PW = $clog2(N_LEDS);

  logic [1:0]                mode_q;
  logic [N_LEDS-1:0]         host_q, status_q, led_q, led_d;
  logic [PWM_BITS-1:0]       bright_q, pwm_q;
  logic [FW-1:0]             flash_q [N_EVENTS];
  logic [BLINK_DIV_BITS-1:0] blink_cnt_q;
  logic                      blink_q;
  logic [CYLON_DIV_BITS-1:0] cyl_cnt_q;
  logic [PW-1:0]             pos_q;
  logic                      down_q;
  logic                      act_q;
  logic [N_EVENTS-1:0]       flash;
  logic [N_LEDS-1:0]         logic_pat, cyl_pat, err_pat, pat;

  always_comb begin
    for (int k = 0; k < N_EVENTS; k++) flash[k] = flash_q[k] != '0;
    cyl_pat = '0;
    cyl_pat[pos_q] = 1'b1;
    logic_pat = status_q;
    logic_pat[N_EVENTS-1:0] = status_q[N_EVENTS-1:0] | flash;
    logic_pat[N_LEDS-1] = blink_q;
    for (int k = 0; k < N_LEDS; k++) err_pat[k] = blink_q ^ (k % 2 == 1);
    // LOGIC mode shows the scan until the first event proves the board is alive
    pat = mode_q == 2'd3 ? '0 :
          mode_q == 2'd1 ? host_q :
          (mode_q == 2'd2 || !act_q) ? cyl_pat : logic_pat;
    led_d = err_i ? err_pat : (&bright_q || pwm_q < bright_q) ? pat : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q      <= '0;
      host_q      <= '0;
      status_q    <= '0;
      bright_q    <= '0;
      pwm_q       <= '0;
      for (int k = 0; k < N_EVENTS; k++) flash_q[k] <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      cyl_cnt_q   <= '0;
      pos_q       <= '0;
      down_q      <= 1'b0;
      act_q       <= 1'b0;
      led_q       <= '0;
    end else begin
      mode_q      <= mode_i;
      host_q      <= host_data_i;
      status_q    <= status_i;
      bright_q    <= brightness_i;
      pwm_q       <= pwm_q + 1'b1;
      for (int k = 0; k < N_EVENTS; k++)
        flash_q[k] <= event_i[k] ? FW'(FLASH_CYCLES) : flash_q[k] - FW'(flash[k]);
      blink_cnt_q <= blink_cnt_q + 1'b1;
      if (blink_cnt_q == '0) blink_q <= ~blink_q;
      cyl_cnt_q   <= cyl_cnt_q + 1'b1;
      // reversal and step share the same tick so the end positions never dwell
      if (&cyl_cnt_q) begin
        if (pos_q == PW'(N_LEDS - 1)) begin
          pos_q  <= pos_q - 1'b1;
          down_q <= 1'b1;
        end else if (pos_q == '0) begin
          pos_q  <= pos_q + 1'b1;
          down_q <= 1'b0;
        end else begin
          pos_q  <= down_q ? pos_q - 1'b1 : pos_q + 1'b1;
        end
      end
      act_q       <= clear_i ? 1'b0 : |event_i ? 1'b1 : act_q;
      led_q       <= led_d;
    end
  end

  assign led_o           = led_q;
  assign activity_seen_o = act_q;
endmodule

// File: tb/tb_led_control_multi.sv
// tb_led_control_multi: directed and random stimulus against a timestamp-based reference model.
module tb_led_control_multi;
  localparam int N = 8, E = 4, F = 10, B = 4, C = 2, P = 2;

  logic         clock = 1'b0, reset_n = 1'b0;
  logic [1:0]   mode_i = '0;
  logic         err_i = 1'b0, clear_i = 1'b0;
  logic [E-1:0] event_i = '0;
  logic [N-1:0] status_i = '0, host_data_i = '0, led_o;
  logic [P-1:0] brightness_i = '1;
  logic         activity_seen_o;

  int checks = 0, errors = 0;
  int n;
  int last_evt [E];
  logic [1:0]   m_mode;
  logic [N-1:0] m_host, m_status, m_led;
  logic [P-1:0] m_bright;
  logic         m_act;

  always #5 clock = ~clock;

  led_control_multi #(.N_LEDS(N), .N_EVENTS(E), .FLASH_CYCLES(F), .BLINK_DIV_BITS(B),
                      .CYLON_DIV_BITS(C), .PWM_BITS(P)) dut (
    .clock(clock), .reset_n(reset_n), .mode_i(mode_i), .err_i(err_i), .clear_i(clear_i),
    .event_i(event_i), .status_i(status_i), .host_data_i(host_data_i),
    .brightness_i(brightness_i), .led_o(led_o), .activity_seen_o(activity_seen_o));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    n = 0;
    m_mode = '0; m_host = '0; m_status = '0; m_bright = '0;
    m_act = 1'b0; m_led = '0;
    for (int k = 0; k < E; k++) last_evt[k] = -1000;
  endtask

  // state after n clocks since reset: blink has toggled ceil(n/2^B) times, cylon has stepped n/2^C times
  task automatic model_edge();
    logic [N-1:0] pat, cyl;
    logic bl;
    int s;
    bl  = 1'(((n + (1 << B) - 1) >> B) & 1);
    s   = (n >> C) % (2 * (N - 1));
    cyl = '0;
    cyl[s <= N - 1 ? s : 2 * (N - 1) - s] = 1'b1;
    if (err_i) begin
      for (int k = 0; k < N; k++) pat[k] = (k % 2 == 0) ? bl : ~bl;
      m_led = pat;
    end else begin
      if (m_mode == 3) pat = '0;
      else if (m_mode == 1) pat = m_host;
      else if (m_mode == 2 || !m_act) pat = cyl;
      else begin
        pat = m_status;
        for (int k = 0; k < E; k++) if (n - last_evt[k] < F) pat[k] = 1'b1;
        pat[N-1] = bl;
      end
      m_led = (m_bright == 3 || (n % (1 << P)) < m_bright) ? pat : '0;
    end
    if (clear_i) m_act = 1'b0;
    else if (|event_i) m_act = 1'b1;
    n++;
    for (int k = 0; k < E; k++) if (event_i[k]) last_evt[k] = n;
    m_mode = mode_i; m_host = host_data_i; m_status = status_i; m_bright = brightness_i;
  endtask

  task automatic tick();
    if (!reset_n) model_reset();
    else model_edge();
    @(posedge clock);
    #1;
    check("led", led_o, m_led);
    check("act", activity_seen_o, m_act);
  endtask

  task automatic ticks(input int cnt);
    for (int i = 0; i < cnt; i++) tick();
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 5; i++) begin
      mode_i = 2'($urandom); err_i = 1'($urandom); event_i = E'($urandom);
      host_data_i = N'($urandom); status_i = N'($urandom);
      tick();
    end
    mode_i = 2'd0; err_i = 0; event_i = '0; host_data_i = '0; status_i = '0; brightness_i = 2'd3;
    reset_n = 1'b1;
    ticks(40);
    mode_i = 2'd1; host_data_i = 8'hA5;
    ticks(4);
    host_data_i = 8'h3C;
    ticks(4);
    mode_i = 2'd0; status_i = 8'h01;
    event_i = 4'b0100; tick(); event_i = '0;
    ticks(4);
    event_i = 4'b0100; tick(); event_i = '0;
    ticks(40);
    mode_i = 2'd2;
    ticks(60);
    mode_i = 2'd1; err_i = 1'b1;
    ticks(40);
    err_i = 1'b0;
    event_i = 4'b0001; clear_i = 1'b1; tick(); event_i = '0; clear_i = 1'b0;
    ticks(3);
    host_data_i = 8'hFF;
    brightness_i = 2'd1; ticks(8);
    brightness_i = 2'd0; ticks(8);
    brightness_i = 2'd3; ticks(8);
    event_i = 4'b1000; tick(); event_i = '0;
    ticks(2);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("async_led", led_o, '0);
    check("async_act", activity_seen_o, 1'b0);
    ticks(2);
    reset_n = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (i % 16 == 0) mode_i = 2'($urandom);
      if (i % 32 == 0) brightness_i = 2'($urandom);
      err_i   = ($urandom_range(0, 15) == 0);
      clear_i = ($urandom_range(0, 31) == 0);
      for (int k = 0; k < E; k++) event_i[k] = ($urandom_range(0, 19) == 0);
      host_data_i = N'($urandom);
      status_i    = N'($urandom);
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
